// File: rtl/rr_channel_sel8_pkg.sv
// Types and helpers shared by the 8-channel round-robin selector.
package rr_channel_sel8_pkg;
  `include "chsel_defs.vh"

  typedef logic [SELW-1:0] ch_idx_t;

  function automatic logic [NCH-1:0] onehot(ch_idx_t i);
    return NCH'(1) << i;
  endfunction
endpackage

// File: rtl/rr_channel_sel8_if.sv
// Channel-side and output-side bus of rr_channel_sel8.
// Optional RR_CHANNEL_SEL8_MASK_EN adds the ch_mask eligibility input.
interface rr_channel_sel8_if #(parameter int WIDTH = 8);
  import rr_channel_sel8_pkg::*;

  logic [NCH-1:0]   req;
  logic [WIDTH-1:0] in0, in1, in2, in3, in4, in5, in6, in7;
  logic             out_ready;
`ifdef RR_CHANNEL_SEL8_MASK_EN
  logic [NCH-1:0]   ch_mask;
`endif
  logic [NCH-1:0]   grant;
  ch_idx_t          sel;
  logic [WIDTH-1:0] out_data;
  logic             out_valid;

`ifdef RR_CHANNEL_SEL8_MASK_EN
  modport master (output req, in0, in1, in2, in3, in4, in5, in6, in7, out_ready, ch_mask,
                  input  grant, sel, out_data, out_valid);
  modport slave  (input  req, in0, in1, in2, in3, in4, in5, in6, in7, out_ready, ch_mask,
                  output grant, sel, out_data, out_valid);
`else
  modport master (output req, in0, in1, in2, in3, in4, in5, in6, in7, out_ready,
                  input  grant, sel, out_data, out_valid);
  modport slave  (input  req, in0, in1, in2, in3, in4, in5, in6, in7, out_ready,
                  output grant, sel, out_data, out_valid);
`endif
endinterface

// File: rtl/chsel_defs.vh
// Shared channel-select constants: channel count, select width and the
// reset value of the round-robin pointer (7, so channel 0 wins first).
`ifndef CHSEL_DEFS_VH
`define CHSEL_DEFS_VH
localparam int          NCH     = 8;
localparam int          SELW    = 3;
localparam logic [2:0]  PTR_RST = 3'd7;
`endif

// File: rtl/rr_pick8.sv
// Combinational round-robin search: first eligible channel scanning upward
// from last+1 with wrap; last itself is reached last, so a sole requester repeats.
module rr_pick8
  import rr_channel_sel8_pkg::*;
(
  input  logic [NCH-1:0] eligible,
  input  ch_idx_t        last,
  output ch_idx_t        winner,
  output logic           any
);
  ch_idx_t idx;

  always_comb begin
    winner = last;
    any    = 1'b0;
    idx    = last;
    for (int k = 1; k <= NCH; k++) begin
      idx = last + SELW'(k);
      if (!any && eligible[idx]) begin
        winner = idx;
        any    = 1'b1;
      end
    end
  end
endmodule

// File: rtl/rr_channel_sel8.sv
// 8-channel round-robin selector with a one-deep registered output stage.
// Define RR_CHANNEL_SEL8_MASK_EN to gate eligibility with bus.ch_mask.
module rr_channel_sel8
  import rr_channel_sel8_pkg::*;
#(parameter int WIDTH = 8)
(
  input logic               clk,
  input logic               rst,
  rr_channel_sel8_if.slave  bus
);
  logic [NCH-1:0]   eligible;
  ch_idx_t          last, winner, sel_q;
  logic             any, load, valid_q;
  logic [WIDTH-1:0] wdata, data_q;

`ifdef RR_CHANNEL_SEL8_MASK_EN
  assign eligible = bus.req & bus.ch_mask;
`else
  assign eligible = bus.req;
`endif

  rr_pick8 u_pick (.eligible(eligible), .last(last), .winner(winner), .any(any));

  // Output slot is free when empty or being drained this cycle.
  assign load = !valid_q || bus.out_ready;

  always_comb begin
    case (winner)
      3'd0:    wdata = bus.in0;
      3'd1:    wdata = bus.in1;
      3'd2:    wdata = bus.in2;
      3'd3:    wdata = bus.in3;
      3'd4:    wdata = bus.in4;
      3'd5:    wdata = bus.in5;
      3'd6:    wdata = bus.in6;
      default: wdata = bus.in7;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      sel_q   <= '0;
      last    <= PTR_RST;
    end else if (load) begin
      valid_q <= any;
      if (any) begin
        data_q <= wdata;
        sel_q  <= winner;
        last   <= winner;
      end
    end
  end

  assign bus.grant     = (!rst && load && any) ? onehot(winner) : '0;
  assign bus.sel       = sel_q;
  assign bus.out_data  = data_q;
  assign bus.out_valid = valid_q;
endmodule
